// File: rtl/nora_map_pkg.sv
// nora_map_pkg: shared definitions for the NORA CPU-to-memory bridge.
//   - region_t:       memory-map regions produced by the address decoder.
//   - bridge_state_t: CPU-cycle sequencer states, also visible on the bridge's
//                     debug state output.
//   - Address constants for the bank registers, I/O page, banked-RAM and ROM
//     windows, plus the offsets of the three I/O device sub-windows.
package nora_map_pkg;

    typedef enum logic [2:0] {
        REGION_LRAM,
        REGION_BRAM,
        REGION_ROM,
        REGION_IO,
        REGION_BANKREG,
        REGION_NONE
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ACTIVE,
        ST_RELEASE
    } bridge_state_t;

    localparam logic [15:0] RAMBANK_ADDR = 16'h0000;
    localparam logic [15:0] ROMBANK_ADDR = 16'h0001;
    localparam logic [7:0]  IO_PAGE      = 8'h9F;
    localparam logic [7:0]  BRAM_HI      = 8'hA0;
    localparam logic [7:0]  ROM_HI       = 8'hC0;

    // Each I/O device owns a 32-byte window inside the I/O page.
    localparam logic [7:0]  IO_WIN_MASK  = 8'hE0;
    localparam logic [7:0]  VERA_OFF     = 8'h20;
    localparam logic [7:0]  AIO_OFF      = 8'h40;
    localparam logic [7:0]  ENET_OFF     = 8'h60;

endpackage

// File: rtl/nora_addr_decode.sv
// nora_addr_decode: purely combinational X16 memory-map decoder.
//   addr    in  16  CPU address (CA[15:12] + MAL[11:0]) as latched for the cycle
//   rambank in  8   RAMBANK register
//   rombank in  5   ROMBANK register
//   region  out     decoded region
//   mah     out 9   SRAM address bits [20:12]
//   io_sel  out 3   one-hot active-high device select {ENET, AIO, VERA}
module nora_addr_decode
    import nora_map_pkg::*;
#(
    parameter logic [7:0] IO_BASE = IO_PAGE
) (
    input  logic [15:0] addr,
    input  logic [7:0]  rambank,
    input  logic [4:0]  rombank,
    output region_t     region,
    output logic [8:0]  mah,
    output logic [2:0]  io_sel
);

    always_comb begin
        region = REGION_LRAM;
        mah    = {5'b0, addr[15:12]};
        io_sel = 3'b000;
        if (addr == RAMBANK_ADDR || addr == ROMBANK_ADDR) begin
            region = REGION_BANKREG;
        end else if (addr[15:8] == IO_BASE) begin
            region = REGION_IO;
            case (addr[7:0] & IO_WIN_MASK)
                VERA_OFF: io_sel = 3'b001;
                AIO_OFF:  io_sel = 3'b010;
                ENET_OFF: io_sel = 3'b100;
                default:  io_sel = 3'b000;
            endcase
        end else if (addr[15:8] >= ROM_HI) begin
            region = REGION_ROM;
            mah    = {2'b11, rombank, addr[13:12]};
        end else if (addr[15:8] >= BRAM_HI) begin
            region = REGION_BRAM;
            mah    = {rambank, addr[12]};
        end
    end

endmodule

// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: per-CPU-cycle bridge between the 65C02 bus and SRAM/IO pins.
// Latches the CPU address at setup_cs, decodes the memory map, drives MAH and
// the SRAM / IO strobes, moves data between CD and MD, and holds the RAMBANK
// ($0000) and ROMBANK ($0001) registers.
//   clk6x, resetn            clock, synchronous active-low reset
//   setup_cs/phi2_rise/fall  one-cycle phaser strobes
//   cpu_addr, cpu_rwn        CPU address and R/W
//   cd_i/cd_o/cd_oe          CPU data bus
//   md_i/md_o/md_oe          memory data bus
//   mah                      SRAM address [20:12]
//   m1csn, mrdn, mwrn        SRAM strobes (active low)
//   vcs0n, vcs1n, vcs2n      VERA / AIO / ENET selects (active low)
//   rambank, rombank         bank registers
//   state                    sequencer state (debug)
// Handshake: there is no back-pressure. The phaser owns the timing; a CPU
// cycle opens with setup_cs (accepted only in IDLE) and closes with phi2_fall,
// at which point write data on cd_i is committed.
module cpu_mem_bridge
    import nora_map_pkg::*;
#(
    parameter logic [7:0] IO_BASE   = 8'h9F,
    parameter int         ROMBANK_W = 5
) (
    input  logic                 clk6x,
    input  logic                 resetn,
    input  logic                 setup_cs,
    input  logic                 phi2_rise,
    input  logic                 phi2_fall,
    input  logic [15:0]          cpu_addr,
    input  logic                 cpu_rwn,
    input  logic [7:0]           cd_i,
    input  logic [7:0]           md_i,
    output logic [7:0]           cd_o,
    output logic                 cd_oe,
    output logic [7:0]           md_o,
    output logic                 md_oe,
    output logic [8:0]           mah,
    output logic                 m1csn,
    output logic                 mrdn,
    output logic                 mwrn,
    output logic                 vcs0n,
    output logic                 vcs1n,
    output logic                 vcs2n,
    output logic [7:0]           rambank,
    output logic [ROMBANK_W-1:0] rombank,
    output bridge_state_t        state
);

    bridge_state_t next_state;
    logic [15:0]   addr_q;
    logic          rwn_q;
    logic          wr_armed;   // phi2_rise seen on a writable SRAM cycle

    region_t       region;
    logic [8:0]    dec_mah;
    logic [2:0]    io_sel;
    logic          is_sram;
    logic          is_io;

    nora_addr_decode #(.IO_BASE(IO_BASE)) u_decode (
        .addr    (addr_q),
        .rambank (rambank),
        .rombank (5'(rombank)),
        .region  (region),
        .mah     (dec_mah),
        .io_sel  (io_sel)
    );

    assign is_sram = (region == REGION_LRAM) || (region == REGION_BRAM) ||
                     (region == REGION_ROM);
    assign is_io   = (region == REGION_IO);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (setup_cs) next_state = ST_DECODE;
            ST_DECODE:  next_state = phi2_fall ? ST_RELEASE : ST_ACTIVE;
            ST_ACTIVE:  if (phi2_fall) next_state = ST_RELEASE;
            ST_RELEASE: next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk6x) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            rwn_q    <= 1'b1;
            wr_armed <= 1'b0;
            rambank  <= '0;
            rombank  <= '0;
        end else begin
            state <= next_state;
            if (state == ST_IDLE && setup_cs) begin
                addr_q <= cpu_addr;
                rwn_q  <= cpu_rwn;
            end
            // ROM is write-protected, so it never arms the write pulse.
            if (phi2_fall || state == ST_IDLE || state == ST_RELEASE) begin
                wr_armed <= 1'b0;
            end else if (phi2_rise && !rwn_q && is_sram && region != REGION_ROM) begin
                wr_armed <= 1'b1;
            end
            if (state == ST_ACTIVE && phi2_fall && !rwn_q && region == REGION_BANKREG) begin
                if (addr_q[0]) rombank <= cd_i[ROMBANK_W-1:0];
                else           rambank <= cd_i;
            end
        end
    end

    // Outputs are gated with resetn so that a mid-cycle reset releases every
    // strobe immediately rather than one edge later.
    always_comb begin
        m1csn = 1'b1;
        mrdn  = 1'b1;
        mwrn  = 1'b1;
        vcs0n = 1'b1;
        vcs1n = 1'b1;
        vcs2n = 1'b1;
        mah   = '0;
        cd_oe = 1'b0;
        md_oe = 1'b0;
        cd_o  = md_i;
        md_o  = cd_i;
        if (resetn && (state == ST_DECODE || state == ST_ACTIVE)) begin
            mah   = dec_mah;
            m1csn = !is_sram;
            vcs0n = !(is_io && io_sel[0]);
            vcs1n = !(is_io && io_sel[1]);
            vcs2n = !(is_io && io_sel[2]);
            mrdn  = !(rwn_q && (is_sram || is_io));
        end
        if (resetn && state == ST_ACTIVE) begin
            if (rwn_q) begin
                cd_oe = 1'b1;
                if (region == REGION_BANKREG) begin
                    cd_o = addr_q[0] ? 8'(rombank) : rambank;
                end
            end else begin
                md_oe = 1'b1;
                // The write pulse ends in the phi2_fall cycle itself.
                mwrn  = !(wr_armed && !phi2_fall);
            end
        end
    end

    setup_in_active: assert property (@(posedge clk6x) disable iff (!resetn)
        !(setup_cs && state == ST_ACTIVE))
        else $warning("cpu_mem_bridge: setup_cs before phi2_fall closed the cycle");

endmodule

// File: doc/cpu_mem_bridge.md
Name: cpu_mem_bridge

Overview:
- Sits directly downstream of the CPU bus-phase generator (phaser) inside NORA and upstream of the SRAM/IO bus pins.
- Per CPU cycle it latches the CPU address and R/W, decodes the X16 memory map, and translates the 16-bit CPU address into a 21-bit SRAM address (MAH[20:12] plus shared MAL).
- Sequences M1CSn/MRDn/MWRn and the VERA/AIO/ENET chip-selects, and bridges data between the CD and MD buses.
- Holds the RAMBANK ($0000) and ROMBANK ($0001) registers with read-back.

Parameters:
- IO_BASE, 8'h9F, high byte of the I/O page.
- ROMBANK_W, 5, implemented ROMBANK width; upper bits read back as 0.

Ports:
- clk6x  in  1  system clock (6x CPHI2).
- resetn  in  1  synchronous active-low reset.
- setup_cs  in  1  phaser strobe, 1 cycle: CPU address and R/W valid.
- phi2_rise  in  1  phaser strobe, 1 cycle: CPHI2 rising edge.
- phi2_fall  in  1  phaser strobe, 1 cycle: CPHI2 falling edge, end of the CPU cycle.
- cpu_addr  in  16  CA[15:12] and MAL[11:0] as sampled.
- cpu_rwn  in  1  CRWn.
- cd_i  in  8  CPU data bus input.
- md_i  in  8  memory data bus input.
- cd_o  out  8  data driven to the CPU.
- cd_oe  out  1  CD output enable.
- md_o  out  8  data driven to SRAM/IO.
- md_oe  out  1  MD output enable.
- mah  out  9  MAH[20:12].
- m1csn, mrdn, mwrn  out  1 each  SRAM strobes, active low.
- vcs0n, vcs1n, vcs2n  out  1 each  VERA, AIO and ENET selects, active low.
- rambank  out  8  RAMBANK register.
- rombank  out  5  ROMBANK register.

Behaviour:
- Reset values (resetn low at a clk6x edge):
  - All *n strobes = 1.
  - cd_oe = 0, md_oe = 0.
  - rambank = 0, rombank = 0.
  - mah = 0, state = IDLE.
- Address decode (computed from the address registered at setup_cs):
  - BANKREG: $0000–$0001.
  - IO: $9F00–$9FFF.
    - $9F20–$9F3F → vcs0n.
    - $9F40–$9F5F → vcs1n.
    - $9F60–$9F7F → vcs2n.
    - All other IO offsets select nothing.
  - BRAM: $A000–$BFFF, mah = {rambank, A12}.
  - ROM: $C000–$FFFF, mah = {2'b11, rombank, A13, A12}.
  - LRAM: everything else, mah = {5'b0, A15:A12}.
  - RAMBANK 0–4 aliases LRAM by design.
- FSM states: IDLE → DECODE → ACTIVE → RELEASE → IDLE.
  - IDLE, on setup_cs: latch address and rwn; go to DECODE.
  - DECODE, 1 cycle:
    - Drive mah.
    - Assert m1csn for LRAM/BRAM/ROM, or the decoded vcsXn for IO.
    - On a read of SRAM or IO, assert mrdn.
  - ACTIVE, holds until phi2_fall:
    - Read: cd_oe = 1. cd_o = md_i for SRAM/IO; for BANKREG, cd_o = rambank or {3'b0, rombank}.
    - Write: md_oe = 1, md_o = cd_i. mwrn is asserted the cycle after phi2_rise, except for ROM (write-protected, mwrn stays 1) and BANKREG.
    - On phi2_fall: a BANKREG write loads cd_i into the addressed register (rombank takes cd_i[4:0]). mwrn deasserts in the same cycle. Go to RELEASE.
  - RELEASE, 1 cycle: deassert chip-selects and mrdn; cd_oe = 0; md_oe = 0; go to IDLE.
- Timing and edge cases:
  - Latency: chip-select is active 1 cycle after setup_cs; write data is committed at phi2_fall.
  - setup_cs arriving outside IDLE is ignored. A protocol error (phi2_fall missing before the next cycle) is flagged only in simulation.
  - phi2_fall in DECODE goes straight to RELEASE with no write pulse.
  - Reset mid-cycle forces every strobe high in the same cycle.
  - md_oe and cd_oe are never 1 simultaneously.

Decomposition:
- Package nora_map_pkg holds:
  - Region enum: LRAM, BRAM, ROM, IO, BANKREG, NONE.
  - Address constants: $0000/$0001, $9F, $A0, $C0.
  - IO sub-window offsets.
- One combinational sub-module, nora_addr_decode: address + bank registers → region, mah, vcs select.

Test Plan:
- Write $0010=$12 and $0011=$34, then read both back → cd_o $12 and $34; m1csn low each cycle; mah=0.
- Write $0000=$AB and $0001=$0C → rambank $AB, rombank $0C; read-back returns $AB and $0C; m1csn stays 1.
- Read $A123 with rambank $AB → mah = {$AB, 0}; read $E000 with rombank $0C → mah = 9'b11_01100_1_0.
- Write $C000=$55 → m1csn pulses low; mwrn stays 1; SRAM contents unchanged.
- Write $9F20=$12 → vcs0n low, md_o=$12, m1csn=1. Read $9F00 → no select asserted; cd_oe still 1.
- Assert resetn low during ACTIVE of a write → all strobes 1 at the next edge; bank registers = 0.
